// File: rtl/texture_ram_bank.sv
// Texel word store for the SimpleGPU texture path: one write port, one read port,
// byte enables, write-first collision bypass, range checking and a zero-fill sequencer.
module texture_ram_bank #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 107120,
  parameter int ADDR_W  = 17,
  parameter int OUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  clear,
  output logic                  busy,
  output logic                  addr_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  // One extra bit so the bound still compares correctly when DEPTH == 2**ADDR_W.
  localparam logic [ADDR_W:0]  DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(DEPTH - 1);

  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_ptr;
  logic              idle;

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_accept;
  logic              rd_accept;
  logic              collide;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_wbe;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;

  logic              rd_v1;
  logic              hit_q;
  logic [BE_W-1:0]   byp_be_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [DATA_W-1:0] rd_word;

  assign idle        = (state == ST_IDLE);
  assign busy        = (state == ST_CLEAR);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign wr_accept   = !rst && idle && wr_en && wr_in_range;
  assign rd_accept   = !rst && idle && rd_en;
  assign collide     = wr_accept && rd_accept && rd_in_range && (wr_addr == rd_addr);

  // Sequencer: CLEAR walks every word once, then hands the ports to the clients.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_ptr == LAST_WORD) begin
        state   <= ST_IDLE;
        clr_ptr <= '0;
      end else begin
        clr_ptr <= clr_ptr + IDX_W'(1);
      end
    end else if (clear) begin
      state   <= ST_CLEAR;
      clr_ptr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_err <= 1'b0;
    end else if (idle && ((wr_en && !wr_in_range) || (rd_en && !rd_in_range))) begin
      addr_err <= 1'b1;
    end
  end

  // NOTE: every output of an always_comb gets a default first, so no path leaves it latched.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr;
    mem_wdata = '0;
    mem_wbe   = '1;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem_we = 1'b1;
      end else if (wr_accept) begin
        mem_we    = 1'b1;
        mem_waddr = wr_idx;
        mem_wdata = wr_data;
        mem_wbe   = wr_be;
      end
    end
  end

  // NOTE: the array and its read register have no reset; the clear sequencer zeroes
  // the contents, which keeps this block mappable onto plain block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_wbe[b]) begin
          mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    if (rd_accept && rd_in_range) begin
      mem_q <= mem[rd_idx];
    end
  end

  // The RAM returns the pre-write word on a collision; the captured write bytes patch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v1      <= 1'b0;
      hit_q      <= 1'b0;
      byp_be_q   <= '0;
      byp_data_q <= '0;
    end else begin
      rd_v1 <= rd_accept;
      if (rd_accept) begin
        hit_q      <= rd_in_range;
        byp_be_q   <= collide ? wr_be : '0;
        byp_data_q <= wr_data;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (hit_q) begin
      for (int b = 0; b < BE_W; b++) begin
        rd_word[8*b +: 8] = byp_be_q[b] ? byp_data_q[8*b +: 8] : mem_q[8*b +: 8];
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              rd_v2;
    logic [DATA_W-1:0] rd_d2;

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_v2 <= 1'b0;
        rd_d2 <= '0;
      end else begin
        rd_v2 <= rd_v1;
        if (rd_v1) begin
          rd_d2 <= rd_word;
        end
      end
    end

    assign rd_valid = rd_v2;
    assign rd_data  = rd_d2;
  end else begin : g_no_out_reg
    assign rd_valid = rd_v1;
    assign rd_data  = rd_word;
  end

endmodule

// File: tb/tb_texture_ram_bank.sv
// Scoreboard bench for texture_ram_bank: two instances (read latency 1 and 2) share
// one stimulus stream and are checked against a small behavioural model.
module tb_texture_ram_bank;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [31:0]       wr_data = '0;
  logic [3:0]        wr_be = '0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              clear = 1'b0;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, busy0, busy1, addr_err0, addr_err1;

  always #5 clk = ~clk;

  texture_ram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(0)) u_lat1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .clear(clear), .busy(busy0), .addr_err(addr_err0));

  texture_ram_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OUT_REG(1)) u_lat2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .clear(clear), .busy(busy1), .addr_err(addr_err1));

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        e0, e1, en;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [31:0] model [DEPTH];
  bit          m_idle = 1'b0;
  int          m_ptr = 0;
  bit          m_err = 1'b0;
  bit          mon_en = 1'b0;
  bit          chk_status = 1'b0;
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Both outputs reset to zero on any sampled rst.
  always @(posedge clk) begin
    if (rst) begin
      last0 = '0;
      last1 = '0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (rd_valid0) begin
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL lat1_unexpected_valid cyc=%0d got=%h", cyc, rd_data0);
        end else begin
          e0 = q0.pop_front();
          if (rd_data0 !== e0.data || cyc != e0.due) begin
            failures++;
            $display("FAIL lat1_read got=%h at cyc %0d, want %h at cyc %0d", rd_data0, cyc, e0.data, e0.due);
          end
          last0 = e0.data;
        end
      end else if (rd_data0 !== last0) begin
        failures++;
        $display("FAIL lat1_hold cyc=%0d got=%h want=%h", cyc, rd_data0, last0);
      end

      checks++;
      if (rd_valid1) begin
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL lat2_unexpected_valid cyc=%0d got=%h", cyc, rd_data1);
        end else begin
          e1 = q1.pop_front();
          if (rd_data1 !== e1.data || cyc != e1.due) begin
            failures++;
            $display("FAIL lat2_read got=%h at cyc %0d, want %h at cyc %0d", rd_data1, cyc, e1.data, e1.due);
          end
          last1 = e1.data;
        end
      end else if (rd_data1 !== last1) begin
        failures++;
        $display("FAIL lat2_hold cyc=%0d got=%h want=%h", cyc, rd_data1, last1);
      end
    end
  end

  // One clock of stimulus; the model advances exactly as the bank should at the next edge.
  task automatic step(input bit we, input int wa, input logic [31:0] wd, input logic [3:0] be,
                      input bit re, input int ra, input bit clr, input bit r);
    @(negedge clk);
    if (chk_status) begin
      checks++;
      if (busy0 !== !m_idle || busy1 !== !m_idle) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b/%b want=%b", cyc, busy0, busy1, !m_idle);
      end
      checks++;
      if (addr_err0 !== m_err || addr_err1 !== m_err) begin
        failures++;
        $display("FAIL addr_err cyc=%0d got=%b/%b want=%b", cyc, addr_err0, addr_err1, m_err);
      end
    end
    rst     = r;
    wr_en   = we;
    wr_addr = ADDR_W'(wa);
    wr_data = wd;
    wr_be   = be;
    rd_en   = re;
    rd_addr = ADDR_W'(ra);
    clear   = clr;
    if (r) begin
      m_idle = 1'b0;
      m_ptr  = 0;
      m_err  = 1'b0;
    end else if (!m_idle) begin
      model[m_ptr] = '0;
      if (m_ptr == DEPTH - 1) begin
        m_idle = 1'b1;
        m_ptr  = 0;
      end else begin
        m_ptr++;
      end
    end else begin
      if (we) begin
        if (wa < DEPTH) begin
          for (int b = 0; b < 4; b++) begin
            if (be[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
          end
        end else begin
          m_err = 1'b1;
        end
      end
      if (re) begin
        if (ra < DEPTH) begin
          en.data = model[ra];
        end else begin
          en.data = '0;
          m_err   = 1'b1;
        end
        en.due = cyc + 1;
        q0.push_back(en);
        en.due = cyc + 2;
        q1.push_back(en);
      end
      if (clr) begin
        m_idle = 1'b0;
        m_ptr  = 0;
      end
    end
  endtask

  task automatic idle_step();
    step(1'b0, 0, '0, '0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    step(1'b1, a, d, be, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic rd(input int a);
    step(1'b0, 0, '0, '0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (4) idle_step();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain outstanding=%0d/%0d want=0/0", q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    step(1'b0, 0, '0, '0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, '0, '0, 1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (rd_valid0 !== 1'b0 || rd_valid1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_rd_valid got=%b/%b want=0/0", rd_valid0, rd_valid1);
    end
    checks++;
    if (rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_rd_data got=%h/%h want=0", rd_data0, rd_data1);
    end
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1 || addr_err0 !== 1'b0 || addr_err1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_status busy=%b/%b addr_err=%b/%b want busy=1 addr_err=0",
               busy0, busy1, addr_err0, addr_err1);
    end
    mon_en     = 1'b1;
    chk_status = 1'b1;
    // Requests during the fill must be ignored.
    for (int i = 0; i < DEPTH; i++) step(1'b1, i, 32'hFFFF_FFFF, 4'hF, 1'b1, i, 1'b0, 1'b0);
  endtask

  task automatic test_zero_fill();
    for (int a = 0; a < DEPTH; a++) rd(a);
    drain();
  endtask

  task automatic test_byte_enable();
    wr(5, 32'hDEAD_BEEF, 4'hF);
    wr(5, 32'h0000_AA00, 4'b0010);
    wr(5, 32'h1234_5678, 4'b0000);
    rd(5);
    drain();
    checks++;
    if (rd_data0 !== 32'hDEAD_AAEF || rd_data1 !== 32'hDEAD_AAEF) begin
      failures++;
      $display("FAIL byte_enable got=%h/%h want=deadaaef", rd_data0, rd_data1);
    end
  endtask

  task automatic test_collision();
    wr(3, 32'hAABB_CCDD, 4'hF);
    step(1'b1, 3, 32'h1122_3344, 4'b1100, 1'b1, 3, 1'b0, 1'b0);
    drain();
    checks++;
    if (rd_data0 !== 32'h1122_CCDD || rd_data1 !== 32'h1122_CCDD) begin
      failures++;
      $display("FAIL collision got=%h/%h want=1122ccdd", rd_data0, rd_data1);
    end
    rd(3);
    drain();
  endtask

  task automatic test_back_to_back();
    wr(1, 32'h0101_0101, 4'hF);
    wr(2, 32'h0202_0202, 4'hF);
    wr(3, 32'h0303_0303, 4'hF);
    rd(1);
    rd(2);
    rd(3);
    drain();
    for (int i = 0; i < 80; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), $urandom,
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, DEPTH - 1)), 1'b0, 1'b0);
    end
    drain();
  endtask

  task automatic test_range();
    wr(4, 32'hCAFE_F00D, 4'hF);
    wr(20, 32'h1234_5678, 4'hF);
    idle_step();
    checks++;
    if (addr_err0 !== 1'b1 || addr_err1 !== 1'b1) begin
      failures++;
      $display("FAIL range_write_err got=%b/%b want=1", addr_err0, addr_err1);
    end
    rd(20);
    rd(4);
    rd(31);
    drain();
    repeat (5) idle_step();
  endtask

  task automatic test_clear_reset();
    for (int a = 0; a < DEPTH; a++) wr(a, 32'hA5A5_0000 | 32'(a), 4'hF);
    step(1'b0, 0, '0, '0, 1'b1, 9, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, int'($urandom_range(0, 31)), $urandom, 4'hF, 1'b1,
           int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
    end
    step(1'b1, 15, 32'hFFFF_FFFF, 4'hF, 1'b1, 15, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, int'($urandom_range(0, 31)), $urandom, 4'hF, 1'b1,
           int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int a = 0; a < DEPTH; a++) rd(a);
    drain();
    checks++;
    if (addr_err0 !== 1'b0 || addr_err1 !== 1'b0) begin
      failures++;
      $display("FAIL clear_reset_err got=%b/%b want=0", addr_err0, addr_err1);
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) model[a] = $urandom;
    test_reset();
    test_zero_fill();
    test_byte_enable();
    test_collision();
    test_back_to_back();
    test_range();
    test_clear_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d bench did not complete", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
